if_stage: RTL

//  Instruction-fetch stage of the 5-stage MIPS pipeline; feeds the decode stage.

---
 rtl/if_stage.sv | 81 ++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, word-addressed instruction memory and IF/ID register.
// Handles ID redirects, hazard stalls, debug freeze and HALT drain.
module if_stage #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          ADDR_W     = 8,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enable,
    input  logic              i_stall,
    input  logic              i_take_branch,
    input  logic [31:0]       i_branch_target_addr,
    input  logic              i_imem_we,
    input  logic [ADDR_W-1:0] i_imem_addr,
    input  logic [31:0]       i_imem_data,
    output logic [31:0]       o_next_pc,
    output logic [31:0]       o_instruction,
    output logic [31:0]       o_pc,
    output logic              o_halt
);

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_word;
    logic [31:0] next_pc_q;
    logic [31:0] instr_q;
    logic        halt_q;
    logic        in_range;

    assign pc_plus4 = pc + 32'd4;
    assign in_range = (pc[31:ADDR_W+2] == '0);

    always_comb begin
        fetch_word = NOP_INSTR;
        if (in_range) begin
            fetch_word = imem[pc[ADDR_W+1:2]];
        end
    end

    // Program-load port has no reset so a loaded program survives a pipeline reset.
    always_ff @(posedge clk) begin
        if (i_imem_we) begin
            imem[i_imem_addr] <= i_imem_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= 32'd0;
            next_pc_q <= 32'd0;
            instr_q   <= NOP_INSTR;
            halt_q    <= 1'b0;
        end else if (i_enable && !i_stall) begin
            if (i_take_branch) begin
                pc        <= i_branch_target_addr & ~32'h3;
                next_pc_q <= 32'd0;
                instr_q   <= NOP_INSTR;
            end else if (halt_q) begin
                next_pc_q <= 32'd0;
                instr_q   <= NOP_INSTR;
            end else begin
                next_pc_q <= pc_plus4;
                instr_q   <= fetch_word;
                if (fetch_word == HALT_INSTR) begin
                    halt_q <= 1'b1;
                end else begin
                    pc <= pc_plus4;
                end
            end
        end
    end

    assign o_pc          = pc;
    assign o_next_pc     = next_pc_q;
    assign o_instruction = instr_q;
    assign o_halt        = halt_q;

endmodule
